ex_mem_buffer: RTL and testbench

//  EX->MEM pipeline stage register with a 2-entry skid buffer and valid/ready handshake.

---
 rtl/ex_mem_buffer_pkg.sv | 26 ++
 rtl/ex_mem_slot.sv | 21 ++
 rtl/ex_mem_buffer.sv | 114 +++++++++++
 tb/tb_ex_mem_buffer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_buffer_pkg.sv
// Shared widths, opcode encodings and skid-buffer state encoding for the EX->MEM stage.
package ex_mem_buffer_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_REG_ADDR_W = 5;
    localparam int DEF_OP_W       = 8;

    localparam logic [DEF_DATA_W-1:0] ZeroWord = '0;

    // alu_op encodings forwarded to MEM for load/store decode
    localparam logic [DEF_OP_W-1:0] EXE_NOP_OP = 8'b0000_0000;
    localparam logic [DEF_OP_W-1:0] EXE_AND_OP = 8'b0010_0100;
    localparam logic [DEF_OP_W-1:0] EXE_OR_OP  = 8'b0010_0101;
    localparam logic [DEF_OP_W-1:0] EXE_XOR_OP = 8'b0010_0110;
    localparam logic [DEF_OP_W-1:0] EXE_NOR_OP = 8'b0010_0111;
    localparam logic [DEF_OP_W-1:0] EXE_ADD_OP = 8'b0010_0000;
    localparam logic [DEF_OP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [DEF_OP_W-1:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {
        SKB_EMPTY = 2'd0,
        SKB_ONE   = 2'd1,
        SKB_TWO   = 2'd2
    } skb_state_e;

endpackage

// File: rtl/ex_mem_slot.sv
// One payload register of the skid buffer: load enable, asynchronous active-low clear.
module ex_mem_slot
    import ex_mem_buffer_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            q <= '0;
        else if (load)
            q <= d;
    end

endmodule

// File: rtl/ex_mem_buffer.sv
// EX->MEM stage register with a 2-entry skid buffer; ex_ready_o and mem_valid_o are registered.
module ex_mem_buffer
    import ex_mem_buffer_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int OP_W       = DEF_OP_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  ex_valid_i,
    output logic                  ex_ready_o,
    input  logic [DATA_W-1:0]     ex_result_i,
    input  logic [REG_ADDR_W-1:0] ex_wd_i,
    input  logic                  ex_wreg_i,
    input  logic [OP_W-1:0]       ex_alu_op_i,
    input  logic [DATA_W-1:0]     ex_reg2_i,
    output logic                  mem_valid_o,
    input  logic                  mem_ready_i,
    output logic [DATA_W-1:0]     mem_result_o,
    output logic [REG_ADDR_W-1:0] mem_wd_o,
    output logic                  mem_wreg_o,
    output logic [OP_W-1:0]       mem_alu_op_o,
    output logic [DATA_W-1:0]     mem_reg2_o
);

    localparam int PW = OP_W + REG_ADDR_W + 1 + 2 * DATA_W;

    skb_state_e state, next_state;

    logic          xfer_in, xfer_out;
    logic          main_load, skid_load, main_from_skid;
    logic [PW-1:0] in_pkt, main_d, main_q, skid_q;
    logic          main_wreg;

    assign xfer_in  = ex_valid_i & ex_ready_o;
    assign xfer_out = mem_valid_o & mem_ready_i;

    assign in_pkt = {ex_alu_op_i, ex_wd_i, ex_wreg_i, ex_result_i, ex_reg2_i};
    assign main_d = main_from_skid ? skid_q : in_pkt;

    always_comb begin
        next_state     = state;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        if (flush_i) begin
            // flush wins: input beat dropped, any concurrent MEM take still happens
            next_state = SKB_EMPTY;
        end else begin
            unique case (state)
                SKB_EMPTY: begin
                    if (xfer_in) begin
                        next_state = SKB_ONE;
                        main_load  = 1'b1;
                    end
                end
                SKB_ONE: begin
                    if (xfer_in && xfer_out) begin
                        main_load = 1'b1;
                    end else if (xfer_in) begin
                        next_state = SKB_TWO;
                        skid_load  = 1'b1;
                    end else if (xfer_out) begin
                        next_state = SKB_EMPTY;
                    end
                end
                SKB_TWO: begin
                    // ready is low here, so only the drain path matters
                    if (xfer_out) begin
                        next_state     = SKB_ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: next_state = SKB_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= SKB_EMPTY;
            ex_ready_o  <= 1'b1;
            mem_valid_o <= 1'b0;
        end else begin
            state       <= next_state;
            ex_ready_o  <= (next_state != SKB_TWO);
            mem_valid_o <= (next_state != SKB_EMPTY);
        end
    end

    ex_mem_slot #(.W(PW)) u_main (
        .clk  (clk),
        .rst  (rst),
        .load (main_load),
        .d    (main_d),
        .q    (main_q)
    );

    ex_mem_slot #(.W(PW)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .load (skid_load),
        .d    (in_pkt),
        .q    (skid_q)
    );

    assign {mem_alu_op_o, mem_wd_o, main_wreg, mem_result_o, mem_reg2_o} = main_q;
    // a stale payload must never look like a register write
    assign mem_wreg_o = main_wreg & mem_valid_o;

endmodule

// File: tb/tb_ex_mem_buffer.sv
// Self-checking bench for ex_mem_buffer: directed vector table, corner sequences, random vs FIFO model.
module tb_ex_mem_buffer;
    import ex_mem_buffer_pkg::*;

    logic        clk, rst, flush_i, ex_valid_i, ex_ready_o, ex_wreg_i;
    logic [31:0] ex_result_i, ex_reg2_i, mem_result_o, mem_reg2_o;
    logic [4:0]  ex_wd_i, mem_wd_o;
    logic [7:0]  ex_alu_op_i, mem_alu_op_o;
    logic        mem_valid_o, mem_ready_i, mem_wreg_o;

    ex_mem_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .ex_valid_i   (ex_valid_i),
        .ex_ready_o   (ex_ready_o),
        .ex_result_i  (ex_result_i),
        .ex_wd_i      (ex_wd_i),
        .ex_wreg_i    (ex_wreg_i),
        .ex_alu_op_i  (ex_alu_op_i),
        .ex_reg2_i    (ex_reg2_i),
        .mem_valid_o  (mem_valid_o),
        .mem_ready_i  (mem_ready_i),
        .mem_result_o (mem_result_o),
        .mem_wd_o     (mem_wd_o),
        .mem_wreg_o   (mem_wreg_o),
        .mem_alu_op_o (mem_alu_op_o),
        .mem_reg2_o   (mem_reg2_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a bounded FIFO of at most two beats
    typedef struct {
        logic [31:0] res;
        logic [4:0]  wd;
        logic        wreg;
        logic [7:0]  op;
        logic [31:0] reg2;
    } beat_t;
    beat_t mq[$];

    task automatic step();
        bit    acc, take;
        beat_t b;
        acc  = ex_valid_i && (mq.size() < 2);
        take = (mq.size() > 0) && mem_ready_i;
        b.res = ex_result_i; b.wd = ex_wd_i; b.wreg = ex_wreg_i;
        b.op = ex_alu_op_i; b.reg2 = ex_reg2_i;
        @(posedge clk);
        if (flush_i) mq.delete();
        else begin
            if (take) void'(mq.pop_front());
            if (acc) mq.push_back(b);
        end
        #1;
    endtask

    task automatic check_model();
        chk("valid", 64'(mem_valid_o), 64'(mq.size() > 0));
        chk("ready", 64'(ex_ready_o), 64'(mq.size() < 2));
        if (mq.size() > 0) begin
            chk("result", 64'(mem_result_o), 64'(mq[0].res));
            chk("wd",     64'(mem_wd_o),     64'(mq[0].wd));
            chk("wreg",   64'(mem_wreg_o),   64'(mq[0].wreg));
            chk("op",     64'(mem_alu_op_o), 64'(mq[0].op));
            chk("reg2",   64'(mem_reg2_o),   64'(mq[0].reg2));
        end else begin
            chk("wreg_idle", 64'(mem_wreg_o), 64'd0);
        end
    endtask

    typedef struct {
        logic        flush, vld, mrdy;
        logic [31:0] res;
        logic        exp_v, exp_r;
        logic [31:0] exp_res;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic f, input logic v, input logic m, input logic [31:0] r,
                       input logic ev, input logic er, input logic [31:0] eres);
        vec_t t;
        t.flush = f; t.vld = v; t.mrdy = m; t.res = r;
        t.exp_v = ev; t.exp_r = er; t.exp_res = eres;
        tbl.push_back(t);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        mq.delete();
    endtask

    initial begin
        rst = 1'b0; flush_i = 1'b0; ex_valid_i = 1'b0; mem_ready_i = 1'b0;
        ex_result_i = '0; ex_wd_i = '0; ex_wreg_i = 1'b0; ex_alu_op_i = '0; ex_reg2_i = '0;
        do_reset();

        chk("rst_valid",  64'(mem_valid_o),  64'd0);
        chk("rst_ready",  64'(ex_ready_o),   64'd1);
        chk("rst_result", 64'(mem_result_o), 64'd0);
        chk("rst_wreg",   64'(mem_wreg_o),   64'd0);
        chk("rst_op",     64'(mem_alu_op_o), 64'd0);

        // streaming, stall into TWO, refused third beat, flush in TWO
        add(0,1,1,32'h1, 1,1,32'h1);
        add(0,1,1,32'h2, 1,1,32'h2);
        add(0,1,1,32'h3, 1,1,32'h3);
        add(0,1,1,32'h4, 1,1,32'h4);
        add(0,0,1,32'h0, 0,1,32'h0);
        add(0,1,0,32'hA, 1,1,32'hA);
        add(0,1,0,32'hB, 1,0,32'hA);
        add(0,1,0,32'hC, 1,0,32'hA);
        add(0,1,1,32'hC, 1,1,32'hB);
        add(0,1,1,32'hC, 1,1,32'hC);
        add(0,0,1,32'h0, 0,1,32'h0);
        add(0,1,0,32'h11,1,1,32'h11);
        add(0,1,0,32'h12,1,0,32'h11);
        add(1,1,0,32'hD, 0,1,32'h0);
        add(0,0,1,32'h0, 0,1,32'h0);
        add(0,0,1,32'h0, 0,1,32'h0);

        ex_wd_i = 5'd1; ex_wreg_i = 1'b1; ex_alu_op_i = EXE_AND_OP;
        foreach (tbl[i]) begin
            flush_i = tbl[i].flush; ex_valid_i = tbl[i].vld;
            mem_ready_i = tbl[i].mrdy; ex_result_i = tbl[i].res;
            step();
            chk($sformatf("tbl%0d_valid", i), 64'(mem_valid_o), 64'(tbl[i].exp_v));
            chk($sformatf("tbl%0d_ready", i), 64'(ex_ready_o),  64'(tbl[i].exp_r));
            chk($sformatf("tbl%0d_wreg", i),  64'(mem_wreg_o),  64'(tbl[i].exp_v));
            if (tbl[i].exp_v)
                chk($sformatf("tbl%0d_result", i), 64'(mem_result_o), 64'(tbl[i].exp_res));
            if (mem_valid_o && mem_result_o == 32'hD)
                chk("flushed_beat_seen", 64'(mem_result_o), 64'd0);
        end
        flush_i = 1'b0;

        // asynchronous reset while holding one beat
        do_reset();
        ex_valid_i = 1'b1; mem_ready_i = 1'b0; ex_result_i = 32'h55;
        step();
        ex_valid_i = 1'b0;
        chk("pre_rst_valid", 64'(mem_valid_o), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_valid",  64'(mem_valid_o),  64'd0);
        chk("async_result", 64'(mem_result_o), 64'd0);
        chk("async_ready",  64'(ex_ready_o),   64'd1);
        chk("async_wreg",   64'(mem_wreg_o),   64'd0);
        #1 rst = 1'b1;
        mq.delete();

        // full-bundle pass-through
        @(negedge clk);
        ex_valid_i = 1'b1; mem_ready_i = 1'b0; ex_result_i = 32'hFFFF0000;
        ex_wd_i = 5'd3; ex_wreg_i = 1'b1; ex_alu_op_i = EXE_OR_OP; ex_reg2_i = 32'h1234_5678;
        step();
        ex_valid_i = 1'b0;
        chk("or_op",     64'(mem_alu_op_o), 64'(EXE_OR_OP));
        chk("or_wd",     64'(mem_wd_o),     64'd3);
        chk("or_wreg",   64'(mem_wreg_o),   64'd1);
        chk("or_result", 64'(mem_result_o), 64'hFFFF0000);
        chk("or_reg2",   64'(mem_reg2_o),   64'h12345678);
        mem_ready_i = 1'b1;
        step();
        chk("drain_wreg", 64'(mem_wreg_o), 64'd0);

        // random traffic against the FIFO model
        do_reset();
        for (int i = 0; i < 800; i++) begin
            flush_i     = ($urandom_range(0, 24) == 0);
            ex_valid_i  = ($urandom_range(0, 3) != 0);
            mem_ready_i = (i % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            ex_result_i = $urandom;
            ex_reg2_i   = $urandom;
            ex_wd_i     = 5'($urandom);
            ex_wreg_i   = 1'($urandom);
            ex_alu_op_i = 8'($urandom);
            step();
            check_model();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
